dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
Sequences decoded instructions from the Decoder into the out-of-order backend. It holds one decoded instruction in a buffer and waits until both a ROB entry and a slot in the target queue are available. The target queue is RS for ALU and branch ops, or LSB for loads and stores. It then issues the instruction with its ROB tag, and back-pressures the Decoder/IFetch via a stall. It sits between Decoder and RS/LSB/ROB and is the single point that serializes allocation of those shared backend resources.

Parameters:
ROB_W, 4, ROB tag width (16-entry ROB)
OP_W, 6, width of internal op code
CNT_W, 32, width of dispatched-instruction counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; 0 freezes all state
dec_valid  in  1  decoded instruction present this cycle
dec_op  in  OP_W  op code
dec_mem  in  1  1 = load/store (route to LSB), 0 = route to RS
dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
dec_imm  in  32  immediate
dec_pc  in  32  instruction PC
dec_is_jump  in  1  branch/jump instruction
dec_pred  in  1  predicted taken
stall_dec  out  1  Decoder must hold its instruction
rob_full, rs_full, lsb_full  in  1 each  target has at most one free slot
rob_tail  in  ROB_W  tag the ROB will assign on next alloc
flush  in  1  mispredict clear from ROB
rob_alloc, rs_issue, lsb_issue  out  1 each  one-cycle allocate/issue pulses
iss_op  out  OP_W
iss_rs1, iss_rs2, iss_rd  out  5 each
iss_imm, iss_pc  out  32 each
iss_tag  out  ROB_W  ROB tag of issued instruction
iss_is_jump, iss_pred  out  1 each
disp_cnt  out  CNT_W  total instructions dispatched since reset

Behaviour:
- Reset (async, rst=1): the buffer is emptied. All pulse outputs are 0, all iss_* are 0, disp_cnt=0, and stall_dec=0.
- State machine on the buffer: EMPTY and HELD.
- can_disp = HELD && !rob_full && (dec_mem ? !lsb_full : !rs_full), evaluated on the buffered instruction's mem bit.
- stall_dec = HELD && !can_disp. It is combinational and is also 1 whenever flush=1.
- Each rdy=1 edge, in priority order:
  - flush=1: buffer goes to EMPTY. All pulse outputs clear to 0. dec_valid is ignored. disp_cnt is unchanged.
  - can_disp: for exactly one cycle, rob_alloc=1 and either rs_issue=1 (mem=0) or lsb_issue=1 (mem=1). iss_* take the buffered fields, iss_tag=rob_tail, and disp_cnt increments by 1. In the same edge the buffer loads a new instruction if dec_valid=1 (stays HELD), otherwise it goes to EMPTY. This gives back-to-back throughput of 1 instruction/cycle.
  - HELD && !can_disp: the buffer is kept and pulses go to 0.
  - EMPTY && dec_valid: the instruction is latched and the state goes to HELD; pulses go to 0.
- Latency: an instruction accepted at edge N is issued at edge N+1 at the earliest. Pulses are registered outputs.
- Exactly one of rs_issue/lsb_issue accompanies each rob_alloc, and never both.
- The full inputs are conservative (asserted at ≤1 free slot), so one registered in-flight issue can never overflow a target.
- rdy=0: no register changes, outputs hold, and consumers are frozen identically, so no duplicate issue occurs.
- disp_cnt wraps modulo 2^CNT_W.
- flush and dispatch in the same cycle: flush wins and no pulse is issued.
- A reset mid-hold drops the buffered instruction.

Test Plan:
- Reset, then dec_valid=1 with op=5, rd=3, imm=0x10, mem=0, rob_tail=2, no full inputs → edge+1 rob_alloc=rs_issue=1, iss_tag=2, iss_rd=3, iss_imm=0x10; disp_cnt=1.
- Stream 4 instructions on consecutive cycles with no full inputs → 4 consecutive issue pulses, stall_dec never 1, disp_cnt=4.
- Buffered load (mem=1) with lsb_full=1 for 3 cycles → stall_dec=1 for 3 cycles with no pulse; after lsb_full drops, lsb_issue=1 and rs_issue stays 0.
- HELD with rob_full=1 and flush=1 → buffer EMPTY, stall_dec=0 next cycle, no rob_alloc, disp_cnt unchanged.
- Issue pending (can_disp) while rdy=0 for 2 cycles → outputs and disp_cnt frozen; when rdy returns to 1, exactly one issue occurs.
- Assert rst asynchronously mid-HELD between edges → stall_dec and pulses go to 0 immediately, disp_cnt=0.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch buffer between the Decoder and the OoO backend.
// Holds one decoded instruction until ROB and its target queue (RS or LSB) can take it.
module dispatch_ctrl #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             dec_valid,
    input  logic [OP_W-1:0]  dec_op,
    input  logic             dec_mem,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic [31:0]      dec_imm,
    input  logic [31:0]      dec_pc,
    input  logic             dec_is_jump,
    input  logic             dec_pred,
    output logic             stall_dec,
    input  logic             rob_full,
    input  logic             rs_full,
    input  logic             lsb_full,
    input  logic [ROB_W-1:0] rob_tail,
    input  logic             flush,
    output logic             rob_alloc,
    output logic             rs_issue,
    output logic             lsb_issue,
    output logic [OP_W-1:0]  iss_op,
    output logic [4:0]       iss_rs1,
    output logic [4:0]       iss_rs2,
    output logic [4:0]       iss_rd,
    output logic [31:0]      iss_imm,
    output logic [31:0]      iss_pc,
    output logic [ROB_W-1:0] iss_tag,
    output logic             iss_is_jump,
    output logic             iss_pred,
    output logic [CNT_W-1:0] disp_cnt
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t state, state_d;

    logic [OP_W-1:0] op_p0;
    logic            mem_p0;
    logic [4:0]      rs1_p0, rs2_p0, rd_p0;
    logic [31:0]     imm_p0, pc_p0;
    logic            jump_p0, pred_p0;

    logic can_disp;
    logic load;
    logic fire;

    // Routing is decided by the buffered instruction, never the one on the decoder bus.
    assign can_disp  = (state == HELD) && !rob_full && (mem_p0 ? !lsb_full : !rs_full);
    assign stall_dec = ((state == HELD) && !can_disp) || flush;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        fire    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (can_disp) begin
            fire = 1'b1;
            if (dec_valid) begin
                state_d = HELD;
                load    = 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end else if (state == HELD) begin
            state_d = HELD;
        end else if (dec_valid) begin
            state_d = HELD;
            load    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else if (rdy) begin
            state <= state_d;
        end
    end

    // Stage p0: buffered decode fields; validity is carried by the FSM state.
    always_ff @(posedge clk) begin
        if (rdy && load) begin
            op_p0   <= dec_op;
            mem_p0  <= dec_mem;
            rs1_p0  <= dec_rs1;
            rs2_p0  <= dec_rs2;
            rd_p0   <= dec_rd;
            imm_p0  <= dec_imm;
            pc_p0   <= dec_pc;
            jump_p0 <= dec_is_jump;
            pred_p0 <= dec_pred;
        end
    end

    // Stage p1: registered issue pulses and payload toward ROB/RS/LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_alloc   <= 1'b0;
            rs_issue    <= 1'b0;
            lsb_issue   <= 1'b0;
            iss_op      <= '0;
            iss_rs1     <= '0;
            iss_rs2     <= '0;
            iss_rd      <= '0;
            iss_imm     <= '0;
            iss_pc      <= '0;
            iss_tag     <= '0;
            iss_is_jump <= 1'b0;
            iss_pred    <= 1'b0;
            disp_cnt    <= '0;
        end else if (rdy) begin
            rob_alloc <= fire;
            rs_issue  <= fire && !mem_p0;
            lsb_issue <= fire && mem_p0;
            if (fire) begin
                iss_op      <= op_p0;
                iss_rs1     <= rs1_p0;
                iss_rs2     <= rs2_p0;
                iss_rd      <= rd_p0;
                iss_imm     <= imm_p0;
                iss_pc      <= pc_p0;
                iss_tag     <= rob_tail;
                iss_is_jump <= jump_p0;
                iss_pred    <= pred_p0;
                disp_cnt    <= disp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios then random traffic against a queue-based model.
module tb_dispatch_ctrl;

    typedef struct packed {
        logic [5:0]  op;
        logic        mem;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        jmp;
        logic        pred;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst, rdy, dec_valid, rob_full, rs_full, lsb_full, flush;
    logic [3:0]  rob_tail;
    ins_t        din;
    logic        stall_dec, rob_alloc, rs_issue, lsb_issue, iss_is_jump, iss_pred;
    logic [5:0]  iss_op;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic [31:0] iss_imm, iss_pc, disp_cnt;
    logic [3:0]  iss_tag;

    int total = 0;
    int bad   = 0;
    int pulses;

    // Reference model: pending instruction queue (depth <= 1) and last issued record.
    ins_t        mq[$];
    logic        m_alloc, m_rs, m_lsb;
    ins_t        m_iss;
    logic [3:0]  m_tag;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    dispatch_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dec_valid(dec_valid), .dec_op(din.op), .dec_mem(din.mem),
        .dec_rs1(din.rs1), .dec_rs2(din.rs2), .dec_rd(din.rd),
        .dec_imm(din.imm), .dec_pc(din.pc), .dec_is_jump(din.jmp), .dec_pred(din.pred),
        .stall_dec(stall_dec),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail(rob_tail), .flush(flush),
        .rob_alloc(rob_alloc), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
        .iss_op(iss_op), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_tag(iss_tag),
        .iss_is_jump(iss_is_jump), .iss_pred(iss_pred), .disp_cnt(disp_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_can();
        if (mq.size() == 0) return 1'b0;
        if (rob_full) return 1'b0;
        return mq[0].mem ? !lsb_full : !rs_full;
    endfunction

    function automatic bit m_stall();
        return ((mq.size() != 0) && !m_can()) || flush;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_alloc = 0; m_rs = 0; m_lsb = 0;
        m_iss = '0; m_tag = '0; m_cnt = '0;
    endtask

    task automatic m_edge();
        ins_t head;
        if (!rdy) return;
        m_alloc = 0; m_rs = 0; m_lsb = 0;
        if (flush) begin
            mq.delete();
        end else if (m_can()) begin
            head    = mq.pop_front();
            m_alloc = 1;
            m_rs    = !head.mem;
            m_lsb   = head.mem;
            m_iss   = head;
            m_tag   = rob_tail;
            m_cnt   = m_cnt + 1;
            if (dec_valid) mq.push_back(din);
        end else if (mq.size() == 0 && dec_valid) begin
            mq.push_back(din);
        end
    endtask

    task automatic check_outs();
        chk("rob_alloc", rob_alloc, m_alloc);
        chk("rs_issue", rs_issue, m_rs);
        chk("lsb_issue", lsb_issue, m_lsb);
        chk("iss_op", iss_op, m_iss.op);
        chk("iss_rs1", iss_rs1, m_iss.rs1);
        chk("iss_rs2", iss_rs2, m_iss.rs2);
        chk("iss_rd", iss_rd, m_iss.rd);
        chk("iss_imm", iss_imm, m_iss.imm);
        chk("iss_pc", iss_pc, m_iss.pc);
        chk("iss_tag", iss_tag, m_tag);
        chk("iss_is_jump", iss_is_jump, m_iss.jmp);
        chk("iss_pred", iss_pred, m_iss.pred);
        chk("disp_cnt", disp_cnt, m_cnt);
    endtask

    // Called at posedge+1; inputs already set by the caller.
    task automatic step();
        #2;
        chk("stall_dec", stall_dec, m_stall());
        @(posedge clk);
        m_edge();
        #1;
        check_outs();
        pulses += int'(rob_alloc);
    endtask

    function automatic ins_t rnd_ins(input logic mem);
        ins_t r;
        r.op = 6'($urandom); r.mem = mem;
        r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
        r.imm = $urandom; r.pc = $urandom;
        r.jmp = 1'($urandom); r.pred = 1'($urandom);
        return r;
    endfunction

    initial begin
        rst = 1; rdy = 1; dec_valid = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
        flush = 0; rob_tail = 0; din = '0; pulses = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        chk("reset_stall", stall_dec, 1'b0);
        rst = 0;

        // First instruction: ALU op routed to RS, tag 2.
        din = '0; din.op = 6'd5; din.rd = 5'd3; din.imm = 32'h10;
        dec_valid = 1; rob_tail = 4'd2;
        step();
        dec_valid = 0;
        step();
        chk("t1_alloc", rob_alloc, 1'b1);
        chk("t1_rs", rs_issue, 1'b1);
        chk("t1_tag", iss_tag, 4'd2);
        chk("t1_rd", iss_rd, 5'd3);
        chk("t1_imm", iss_imm, 32'h10);
        chk("t1_cnt", disp_cnt, 32'd1);

        // Back-to-back stream of four.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            din = rnd_ins(1'($urandom)); dec_valid = 1; rob_tail = 4'(i + 3);
            step();
        end
        dec_valid = 0;
        step();
        chk("stream_pulses", pulses, 4);
        chk("stream_cnt", disp_cnt, 32'd5);

        // Load blocked by LSB for three cycles.
        din = rnd_ins(1'b1); dec_valid = 1; lsb_full = 1;
        step();
        dec_valid = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lsbfull_stall", stall_dec, 1'b1);
        end
        chk("lsbfull_nopulse", pulses, 0);
        lsb_full = 0;
        step();
        chk("lsb_issue", lsb_issue, 1'b1);
        chk("lsb_no_rs", rs_issue, 1'b0);

        // Flush while held against a full ROB.
        din = rnd_ins(1'b0); dec_valid = 1; rob_full = 1;
        step();
        dec_valid = 0;
        step();
        flush = 1;
        step();
        flush = 0;
        step();
        chk("flush_stall", stall_dec, 1'b0);
        chk("flush_alloc", rob_alloc, 1'b0);
        chk("flush_cnt", disp_cnt, 32'd6);
        rob_full = 0;

        // Pending issue frozen by rdy=0.
        din = rnd_ins(1'b0); dec_valid = 1; rob_tail = 4'd9;
        step();
        dec_valid = 0; rdy = 0;
        step();
        step();
        chk("frz_alloc", rob_alloc, 1'b0);
        chk("frz_cnt", disp_cnt, 32'd6);
        rdy = 1;
        pulses = 0;
        step();
        step();
        chk("unfrz_pulses", pulses, 1);
        chk("unfrz_cnt", disp_cnt, 32'd7);

        // Asynchronous reset between edges while an instruction is held.
        din = rnd_ins(1'b1); dec_valid = 1; rob_full = 1;
        step();
        dec_valid = 0;
        step();
        chk("pre_rst_stall", stall_dec, 1'b1);
        #2 rst = 1;
        #1;
        m_reset();
        chk("arst_stall", stall_dec, 1'b0);
        chk("arst_alloc", rob_alloc, 1'b0);
        chk("arst_cnt", disp_cnt, 32'd0);
        chk("arst_op", iss_op, 6'd0);
        #1 rst = 0;
        @(posedge clk);
        #1;
        check_outs();
        rob_full = 0;

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            rdy       = ($urandom_range(9) != 0);
            flush     = ($urandom_range(19) == 0);
            rob_full  = ($urandom_range(3) == 0);
            rs_full   = ($urandom_range(3) == 0);
            lsb_full  = ($urandom_range(3) == 0);
            dec_valid = ($urandom_range(9) < 7);
            rob_tail  = 4'($urandom);
            din       = rnd_ins(1'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
